// File: rtl/pc_gen.sv
// Purpose : fetch-PC generator; holds the fetch PC, advances it on accepted
//           fetches, and steers it to branch/jump/jr/exception/eret targets.
// Latency : a redirect accepted in cycle N is the fetch PC in cycle N+1;
//           pc4_o and fetch_valid_o are combinational from the state register.
// Backpressure: the PC advances only on fetch_valid_o & fetch_ready_i. A decode
//           redirect that cannot be accepted is parked until stall_i drops.
//
// Ports
//   clk_i          clock, all state on the rising edge
//   rst_ni         synchronous reset, active-low, overrides every other input
//   stall_i        pipeline stall from the hazard unit
//   fetch_ready_i  imem accepts the request this cycle
//   fetch_valid_o  pc_o is a live fetch request
//   pc_o / pc4_o   current fetch PC and pc_o + INC
//   br_taken_i, br_pc4_i, br_off_i   decode branch resolution (offset in words)
//   j_en_i, j_index_i                decode J/JAL
//   jr_en_i, jr_target_i             decode JR/JALR
//   exc_en_i                         exception taken at commit
//   eret_en_i, epc_i                 ERET at commit and its return PC
//   redir_pend_o   a decode redirect is parked
//   addr_err_o     one-cycle pulse after pc_o is loaded with a misaligned value

module pc_gen #(
    parameter int              PC_W      = 32,
    parameter int              IDX_W     = 26,
    parameter int              INC       = 4,
    parameter logic [PC_W-1:0] RESET_VEC = 32'hBFC00000,
    parameter logic [PC_W-1:0] EXC_VEC   = 32'hBFC00380
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_i,
    input  logic             fetch_ready_i,
    output logic             fetch_valid_o,
    output logic [PC_W-1:0]  pc_o,
    output logic [PC_W-1:0]  pc4_o,
    input  logic             br_taken_i,
    input  logic [PC_W-1:0]  br_pc4_i,
    input  logic [PC_W-1:0]  br_off_i,
    input  logic             j_en_i,
    input  logic [IDX_W-1:0] j_index_i,
    input  logic             jr_en_i,
    input  logic [PC_W-1:0]  jr_target_i,
    input  logic             exc_en_i,
    input  logic             eret_en_i,
    input  logic [PC_W-1:0]  epc_i,
    output logic             redir_pend_o,
    output logic             addr_err_o
);

    localparam logic [PC_W-1:0] INC_V = PC_W'(INC);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
    logic              addr_err_q, addr_err_d;

    // ------------------------------------------------------------------
    // Target computation
    // ------------------------------------------------------------------
    logic              commit_redir;
    logic [PC_W-1:0]   commit_tgt;
    logic              dec_redir;
    logic [PC_W-1:0]   dec_tgt;
    logic [PC_W-1:0]   jump_tgt;
    logic [PC_W-1:0]   br_tgt;
    logic              accept;
    logic              pc_we;

    // J keeps the region bits of the delay-slot PC and replaces the rest.
    assign jump_tgt = {br_pc4_i[PC_W-1:IDX_W+2], j_index_i, 2'b00};
    // Offset is in words; the shift drops the top two bits, which is the
    // same as a modulo-2^PC_W add of (offset * 4).
    assign br_tgt   = br_pc4_i + {br_off_i[PC_W-3:0], 2'b00};

    // Commit-stage redirects outrank anything decode is asking for: they
    // also kill a parked redirect, so they are kept separate.
    assign commit_redir = exc_en_i | eret_en_i;
    assign commit_tgt   = exc_en_i ? EXC_VEC : epc_i;

    assign dec_redir = jr_en_i | j_en_i | br_taken_i;

    always_comb begin
        dec_tgt = br_tgt;
        if (jr_en_i) begin
            dec_tgt = jr_target_i;
        end else if (j_en_i) begin
            dec_tgt = jump_tgt;
        end
    end

    // ------------------------------------------------------------------
    // Fetch handshake
    // ------------------------------------------------------------------
    assign fetch_valid_o = (state_q == ST_RUN) & ~stall_i;
    assign accept        = fetch_valid_o & fetch_ready_i;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        pc_we     = 1'b0;

        if (commit_redir) begin
            // Takes effect from any state, ignoring stall and fetch_ready.
            pc_d    = commit_tgt;
            pc_we   = 1'b1;
            state_d = ST_RUN;
        end else begin
            unique case (state_q)
                ST_BOOT: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (accept) begin
                        pc_we = 1'b1;
                        pc_d  = dec_redir ? dec_tgt : pc_q + INC_V;
                    end else if (dec_redir) begin
                        // Decode only presents the redirect for one cycle,
                        // so it has to be captured now or it is lost.
                        pend_pc_d = dec_tgt;
                        state_d   = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Decode inputs here belong to the wrong path.
                    if (!stall_i) begin
                        pc_d    = pend_pc_q;
                        pc_we   = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end

        addr_err_d = pc_we & (pc_d[1:0] != 2'b00);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VEC;
            pend_pc_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            addr_err_q <= addr_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pc_o         = pc_q;
    assign pc4_o        = pc_q + INC_V;
    assign redir_pend_o = (state_q == ST_HOLD);
    assign addr_err_o   = addr_err_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    localparam logic [31:0] RST_V = 32'hBFC00000;
    localparam logic [31:0] EXC_V = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst_n, stall, fetch_ready, fetch_valid;
    logic [31:0] pc, pc4;
    logic        br_taken, j_en, jr_en, exc_en, eret_en;
    logic [31:0] br_pc4, br_off, jr_target, epc;
    logic [25:0] j_index;
    logic        redir_pend, addr_err;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .stall_i       (stall),
        .fetch_ready_i (fetch_ready),
        .fetch_valid_o (fetch_valid),
        .pc_o          (pc),
        .pc4_o         (pc4),
        .br_taken_i    (br_taken),
        .br_pc4_i      (br_pc4),
        .br_off_i      (br_off),
        .j_en_i        (j_en),
        .j_index_i     (j_index),
        .jr_en_i       (jr_en),
        .jr_target_i   (jr_target),
        .exc_en_i      (exc_en),
        .eret_en_i     (eret_en),
        .epc_i         (epc),
        .redir_pend_o  (redir_pend),
        .addr_err_o    (addr_err)
    );

    typedef struct {
        bit          rst_n, stall, rdy;
        bit          br, j, jr, exc, eret;
        logic [31:0] br_pc4, br_off, jr_t, epc;
        logic [25:0] jidx;
    } vin_t;

    typedef struct {
        vin_t        in;
        int          exp_fv;   // 2 = not checked
        logic [31:0] exp_pc;
        bit          exp_rp, exp_ae;
    } row_t;

    typedef enum int { K_NONE, K_BR, K_J, K_JR, K_EXC, K_ERET } kind_e;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic row_t mk(bit rn, bit st, bit rd, kind_e k, logic [31:0] a,
                                logic [31:0] b, int fv, logic [31:0] epc_v, bit rp, bit ae);
        row_t r;
        r.in = '{rst_n: rn, stall: st, rdy: rd, br: 1'b0, j: 1'b0, jr: 1'b0, exc: 1'b0,
                 eret: 1'b0, br_pc4: 32'h0, br_off: 32'h0, jr_t: 32'h0, epc: 32'h0, jidx: 26'h0};
        case (k)
            K_BR:   begin r.in.br = 1'b1; r.in.br_pc4 = a; r.in.br_off = b; end
            K_J:    begin r.in.j = 1'b1; r.in.br_pc4 = a; r.in.jidx = b[25:0]; end
            K_JR:   begin r.in.jr = 1'b1; r.in.jr_t = a; end
            K_EXC:  r.in.exc = 1'b1;
            K_ERET: begin r.in.eret = 1'b1; r.in.epc = a; end
            default: ;
        endcase
        r.exp_fv = fv;
        r.exp_pc = epc_v;
        r.exp_rp = rp;
        r.exp_ae = ae;
        return r;
    endfunction

    task automatic apply(input vin_t v);
        rst_n = v.rst_n; stall = v.stall; fetch_ready = v.rdy;
        br_taken = v.br; j_en = v.j; jr_en = v.jr; exc_en = v.exc; eret_en = v.eret;
        br_pc4 = v.br_pc4; br_off = v.br_off; jr_target = v.jr_t; epc = v.epc;
        j_index = v.jidx;
    endtask

    // Reference model state
    logic [31:0] m_pc, m_pend;
    bit          m_boot, m_parked, m_ae;

    function automatic logic [31:0] region_jump(logic [31:0] p4, logic [25:0] idx);
        return (p4 & 32'hF000_0000) | ({6'd0, idx} * 4);
    endfunction

    task automatic model_step(input vin_t v);
        logic [31:0] tgt;
        bit          has;
        has = v.jr | v.j | v.br;
        if (v.jr)     tgt = v.jr_t;
        else if (v.j) tgt = region_jump(v.br_pc4, v.jidx);
        else          tgt = v.br_pc4 + v.br_off * 4;
        if (!v.rst_n) begin
            m_pc = RST_V; m_boot = 1; m_parked = 0; m_ae = 0; m_pend = 0;
        end else if (v.exc || v.eret) begin
            m_pc = v.exc ? EXC_V : v.epc;
            m_boot = 0; m_parked = 0; m_ae = (m_pc % 4) != 0;
        end else if (m_boot) begin
            m_boot = 0; m_ae = 0;
        end else if (m_parked) begin
            if (!v.stall) begin
                m_pc = m_pend; m_parked = 0; m_ae = (m_pc % 4) != 0;
            end else begin
                m_ae = 0;
            end
        end else if (!v.stall && v.rdy) begin
            m_pc = has ? tgt : m_pc + 4;
            m_ae = (m_pc % 4) != 0;
        end else begin
            if (has) begin
                m_pend = tgt; m_parked = 1;
            end
            m_ae = 0;
        end
    endtask

    row_t vec[$];

    initial begin
        vin_t v;

        v = mk(0, 0, 0, K_NONE, 0, 0, 2, 0, 0, 0).in;
        apply(v);

        //          rst st rdy kind    a             b             fv pc            rp ae
        vec.push_back(mk(0, 0, 1, K_NONE, 0,            0,            2, RST_V,        0, 0));
        vec.push_back(mk(0, 0, 1, K_NONE, 0,            0,            0, RST_V,        0, 0));
        vec.push_back(mk(1, 0, 1, K_NONE, 0,            0,            0, RST_V,        0, 0));
        vec.push_back(mk(1, 0, 1, K_NONE, 0,            0,            1, 32'hBFC00004, 0, 0));
        vec.push_back(mk(1, 0, 1, K_NONE, 0,            0,            1, 32'hBFC00008, 0, 0));
        vec.push_back(mk(1, 0, 1, K_NONE, 0,            0,            1, 32'hBFC0000C, 0, 0));
        vec.push_back(mk(1, 0, 0, K_NONE, 0,            0,            1, 32'hBFC0000C, 0, 0));
        vec.push_back(mk(1, 1, 1, K_NONE, 0,            0,            0, 32'hBFC0000C, 0, 0));
        vec.push_back(mk(1, 0, 1, K_BR,   32'h00000100, 32'hFFFFFFFF, 1, 32'h000000FC, 0, 0));
        vec.push_back(mk(1, 0, 1, K_J,    32'h80000010, 32'h00000040, 1, 32'h80000100, 0, 0));
        vec.push_back(mk(1, 0, 1, K_JR,   32'h00000102, 0,            1, 32'h00000102, 0, 1));
        vec.push_back(mk(1, 0, 1, K_JR,   32'hFFFFFFFC, 0,            1, 32'hFFFFFFFC, 0, 0));
        vec.push_back(mk(1, 0, 1, K_NONE, 0,            0,            1, 32'h00000000, 0, 0));
        vec.push_back(mk(1, 1, 1, K_BR,   32'h00000200, 0,            0, 32'h00000000, 1, 0));
        vec.push_back(mk(1, 1, 1, K_JR,   32'h00000300, 0,            0, 32'h00000000, 1, 0));
        vec.push_back(mk(1, 0, 1, K_JR,   32'h00000300, 0,            0, 32'h00000200, 0, 0));
        vec.push_back(mk(1, 0, 1, K_NONE, 0,            0,            1, 32'h00000204, 0, 0));
        vec.push_back(mk(1, 1, 1, K_BR,   32'h00000300, 0,            0, 32'h00000204, 1, 0));
        vec.push_back(mk(1, 1, 0, K_EXC,  0,            0,            0, EXC_V,        0, 0));
        vec.push_back(mk(1, 0, 1, K_NONE, 0,            0,            1, 32'hBFC00384, 0, 0));
        vec.push_back(mk(1, 1, 1, K_BR,   32'h00000400, 0,            0, 32'hBFC00384, 1, 0));
        vec.push_back(mk(0, 1, 1, K_NONE, 0,            0,            0, RST_V,        0, 0));
        vec.push_back(mk(1, 0, 1, K_NONE, 0,            0,            0, RST_V,        0, 0));
        vec.push_back(mk(1, 1, 0, K_ERET, 32'h00001000, 0,            0, 32'h00001000, 0, 0));
        vec.push_back(mk(1, 0, 1, K_NONE, 0,            0,            1, 32'h00001004, 0, 0));

        // Directed table: fetch_valid checked before the edge, registered
        // outputs checked just after it.
        foreach (vec[i]) begin
            @(negedge clk);
            apply(vec[i].in);
            #1;
            if (vec[i].exp_fv != 2) chk($sformatf("tbl%0d_fv", i), {31'd0, fetch_valid}, vec[i].exp_fv);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_pc", i), pc, vec[i].exp_pc);
            chk($sformatf("tbl%0d_pc4", i), pc4, vec[i].exp_pc + 32'd4);
            chk($sformatf("tbl%0d_rp", i), {31'd0, redir_pend}, {31'd0, vec[i].exp_rp});
            chk($sformatf("tbl%0d_ae", i), {31'd0, addr_err}, {31'd0, vec[i].exp_ae});
        end

        // Randomised run against the reference model, starting from reset.
        @(negedge clk);
        v = mk(0, 0, 0, K_NONE, 0, 0, 2, 0, 0, 0).in;
        apply(v);
        model_step(v);
        @(posedge clk);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            v.rst_n  = ($urandom_range(0, 99) >= 2);
            v.stall  = ($urandom_range(0, 99) < 30);
            v.rdy    = ($urandom_range(0, 99) < 70);
            v.exc    = ($urandom_range(0, 99) < 3);
            v.eret   = ($urandom_range(0, 99) < 3);
            v.jr     = ($urandom_range(0, 99) < 10);
            v.j      = ($urandom_range(0, 99) < 10);
            v.br     = ($urandom_range(0, 99) < 15);
            v.br_pc4 = $urandom & 32'hFFFFFFFC;
            v.br_off = (($urandom_range(0, 1) == 1) ? 32'hFFFF0000 : 32'h0) | $urandom_range(0, 16'hFFFF);
            v.jr_t   = $urandom & 32'hFFFFFFFC;
            v.epc    = $urandom & 32'hFFFFFFFC;
            v.jidx   = 26'($urandom);
            apply(v);
            #1;
            chk("rnd_fv", {31'd0, fetch_valid}, {31'd0, !m_boot && !m_parked && !v.stall});
            chk("rnd_pc", pc, m_pc);
            chk("rnd_pc4", pc4, m_pc + 32'd4);
            chk("rnd_rp", {31'd0, redir_pend}, {31'd0, m_parked});
            chk("rnd_ae", {31'd0, addr_err}, {31'd0, m_ae});
            model_step(v);
            @(posedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
